// File: rtl/fade_pwm_multi.sv
// Multi-channel LED fade engine: per-channel ramp, optional gamma curve,
// period-aligned shadow duty load and registered PWM outputs.
module fade_pwm_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PRE_W    = 16
) (
  input  logic                      CLOCK_50,
  input  logic                      Reset,
  input  logic [1:0]                Mode,
  input  logic [PRE_W-1:0]          Rate,
  input  logic                      GammaEn,
  input  logic [CHANNELS-1:0]       Enable,
  input  logic [CHANNELS*WIDTH-1:0] Level,
  output logic [CHANNELS-1:0]       Pwm,
  output logic [CHANNELS*WIDTH-1:0] Duty,
  output logic [WIDTH-1:0]          Count,
  output logic                      Tick
);

  localparam int unsigned PW      = 2 * WIDTH;
  localparam int unsigned STAGGER = (2 ** WIDTH) / CHANNELS;
  localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] LAST = MAX - WIDTH'(1);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SAW  = 2'b01;
  localparam logic [1:0] MODE_TRI  = 2'b10;
  localparam logic [1:0] MODE_DIR  = 2'b11;

  logic [PRE_W-1:0] pre_q;
  logic             tick_c;
  logic             load_c;

  assign tick_c = (pre_q >= Rate);
  assign load_c = (Count == LAST);

  // Ramp-rate prescaler; the >= compare lets a lowered Rate take effect at once.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      pre_q <= '0;
      Tick  <= 1'b0;
    end else begin
      pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);
      Tick  <= tick_c;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      Count <= '0;
    end else begin
      Count <= load_c ? '0 : Count + WIDTH'(1);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0] ramp_q, ramp_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] duty_q;
    logic             pwm_q;
    logic [WIDTH-1:0] gamma_c;

    always_comb begin
      ramp_d = ramp_q;
      dir_d  = dir_q;
      if (Enable[g]) begin
        case (Mode)
          MODE_HOLD: ;
          MODE_SAW: begin
            if (tick_c) ramp_d = ramp_q + WIDTH'(1);
          end
          MODE_TRI: begin
            if (tick_c) begin
              if (dir_q) begin
                if (ramp_q == MAX) begin
                  dir_d  = 1'b0;
                  ramp_d = MAX - WIDTH'(1);
                end else begin
                  ramp_d = ramp_q + WIDTH'(1);
                end
              end else begin
                if (ramp_q == '0) begin
                  dir_d  = 1'b1;
                  ramp_d = WIDTH'(1);
                end else begin
                  ramp_d = ramp_q - WIDTH'(1);
                end
              end
            end
          end
          MODE_DIR: ramp_d = Level[g*WIDTH +: WIDTH];
          default: ;
        endcase
      end
    end

    // Gamma approximation r*(r+1)/2^W maps 0->0 and MAX->MAX exactly.
    assign gamma_c = WIDTH'((PW'(ramp_q) * (PW'(ramp_q) + PW'(1))) >> WIDTH);

    always_comb begin
      target_d = ramp_q;
      if (!Enable[g]) begin
        target_d = '0;
      end else if (GammaEn) begin
        target_d = gamma_c;
      end
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
      if (Reset) begin
        ramp_q   <= WIDTH'(g * STAGGER);
        dir_q    <= 1'b1;
        target_q <= '0;
        duty_q   <= '0;
        pwm_q    <= 1'b0;
      end else begin
        ramp_q   <= ramp_d;
        dir_q    <= dir_d;
        target_q <= target_d;
        if (load_c) duty_q <= target_q;
        pwm_q    <= (Count < duty_q);
      end
    end

    assign Pwm[g]                  = pwm_q;
    assign Duty[g*WIDTH +: WIDTH]  = duty_q;
  end

endmodule

// File: doc/fade_pwm_multi.md
# fade_pwm_multi

Parametrised multi-channel LED fade engine with per-channel ramp generators, an arithmetic gamma curve and glitch-free PWM outputs. It is the generalised successor to the single-channel switch-driven fade path: each channel gets its own brightness ramp and PWM output, phase-staggered across channels. Selectable modes are sawtooth, triangle "breathing", hold, and direct level. It sits between the switch/control logic and the LEDR/LEDG drivers of the board top level.

## Interface
- CHANNELS, 4: number of independent PWM channels (1..2^WIDTH)
- WIDTH, 8: brightness and PWM resolution in bits; MAX = 2^WIDTH-1
- PRE_W, 16: width of the ramp-rate prescaler

- CLOCK_50  in  1  system clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- Mode  in  2  00 hold, 01 sawtooth, 10 triangle, 11 direct
- Rate  in  PRE_W  ramp step period minus one, in clocks
- GammaEn  in  1  1 = apply gamma curve, 0 = linear
- Enable  in  CHANNELS  per-channel enable
- Level  in  CHANNELS*WIDTH  direct-mode levels; channel i at [i*WIDTH +: WIDTH]
- Pwm  out  CHANNELS  PWM outputs
- Duty  out  CHANNELS*WIDTH  active duty per channel, same packing as Level
- Count  out  WIDTH  PWM period counter
- Tick  out  1  one-clock pulse on each ramp step

## Operation
- Prescaler Pre counts 0..Rate.
  - When Pre >= Rate: Pre <= 0 and Tick pulses for that clock. Otherwise Pre <= Pre+1.
  - Rate=0 gives a Tick every clock.
  - Tick is generated in all modes.
- Ramp register R[i] (WIDTH bits) and direction bit D[i] (1 = up) per channel.
  - R[i] changes only when Enable[i]=1. A disabled channel's ramp is frozen.
  - Hold: R unchanged.
  - Sawtooth, on Tick: R <= R+1, wrapping MAX->0. D is unchanged.
  - Triangle, on Tick:
    - If D=1: at R=MAX set D<=0 and R<=MAX-1; otherwise R<=R+1.
    - If D=0: at R=0 set D<=1 and R<=1; otherwise R<=R-1.
    - Peaks occur once per cycle; the triangle period is 2*MAX ticks.
  - Direct: R[i] <= Level[i] every clock, independent of Tick.
  - A mode change keeps the current R and D; there is no reload.
- Target stage T[i], registered:
  - If Enable[i]=0: T <= 0.
  - Else if GammaEn=1: T <= (R*(R+1)) >> WIDTH, computed in 2*WIDTH bits. This gives g(0)=0, g(MAX)=MAX, and g(128)=64 at WIDTH=8.
  - Else: T <= R.
- PWM counter Count runs 0..MAX-1 and wraps to 0 (period MAX clocks).
- Shadow load: when Count == MAX-1, Duty[i] <= T[i] for all channels simultaneously. Duty never changes mid-period.
- Output: Pwm[i] = (Count < Duty[i]), registered.
  - Duty=0 keeps Pwm low for the whole period.
  - Duty=MAX keeps Pwm high for the whole period.

## Timing
- Reset values (asynchronous):
  - R[i] = i*((MAX+1)/CHANNELS), using integer division, to give the phase stagger
  - D[i] = 1
  - Pre = 0
  - Count = 0
  - T = 0
  - Duty = 0
  - Pwm = 0
  - Tick = 0
- Reset asserted mid-period forces all of the above immediately. The first period after release starts at Count=0.
- Pwm registered: Pwm[i] at edge n+1 reflects Count and Duty at edge n. It therefore lags Count by one clock.
- Direct-mode latency:
  - Level change sampled at edge k appears in R at k, in T at k+1.
  - It appears in Duty at the first Count==MAX-1 edge at or after k+2.
  - It appears on Pwm one clock after that.
- Ramp step to T: 1 clock after the Tick edge.
- Enable[i] falling: T[i]=0 on the next clock, and Duty[i]=0 from the next period.
- Simultaneous Tick and shadow load on one edge: Duty loads the old T; the new value follows in the next period.
- Rate change mid-count: takes effect immediately via the >= compare, with no stall.

## Test plan
- Reset at WIDTH=8, CHANNELS=4 -> R = 0, 64, 128, 192; all Pwm=0; Duty=0 for the first 255 clocks; Count=0 after release.
- Direct, GammaEn=0, Level ch0=0, ch1=255, ch2=128 -> after the first shadow load: ch0 Pwm never high, ch1 always high, ch2 high for exactly 128 of 255 clocks.
- Direct, GammaEn=1, ch0 Level 128 / 255 / 1 -> Duty 64 / 255 / 0.
- Sawtooth, Rate=3 -> Tick every 4 clocks; ch0 R steps 0,1,2...; 255 -> 0 wraps.
- Triangle, Rate=0, ch3 starting at 192 -> rises to 255, then 254, falls to 0, then 1; D flips exactly at 255 and at 0.
- Enable[2] deasserted mid-period -> Duty[2] holds until Count==254, then becomes 0; R[2] frozen; other channels are unaffected. Reset asserted mid-ramp -> immediate return to reset values.
